// File: rtl/fifo_channel_monitor.sv
// fifo_channel_monitor: shadow-occupancy checker for a FIFO bank; FIFO_CHANNEL_MONITOR_SVA_EN adds assertions
module fifo_channel_monitor #(
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 32,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int ERR_CNT_W = 8,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           write_en,
  input  logic [CHANNELS-1:0]           read_en,
  input  logic [CHANNELS-1:0]           full,
  input  logic [CHANNELS-1:0]           empty,
  input  logic [CHANNELS*(PTR_W+1)-1:0] count,
  input  logic                          clear,
  output logic [CHANNELS-1:0]           err_overflow,
  output logic [CHANNELS-1:0]           err_underflow,
  output logic [CHANNELS-1:0]           err_mismatch,
  output logic                          err_any,
  output logic [CHANNELS*(PTR_W+1)-1:0] high_water,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic                          first_err_valid,
  output logic [CH_W-1:0]               first_err_chan,
  output logic [1:0]                    first_err_code
);
  localparam int W = PTR_W + 1;
  localparam logic [W-1:0] FULL_V = W'(DEPTH);
  localparam logic [W-1:0] ONE = W'(1);
  logic rst_q;
  logic [CHANNELS-1:0] ovf, unf, mis;
  logic any_v;
  logic [CH_W-1:0] f_chan;
  logic [1:0] f_code;
  // reset asserts immediately and is released on a clock edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_q <= 1'b0;
    else rst_q <= 1'b1;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [W-1:0] sh, hw, sh_nx, cnt;
    logic wa, ra;
    assign cnt = count[g*W +: W];
    assign wa = write_en[g] && sh != FULL_V;
    assign ra = read_en[g] && sh != '0;
    assign sh_nx = (wa && !ra) ? sh + ONE : (ra && !wa) ? sh - ONE : sh;
    assign ovf[g] = write_en[g] && full[g];
    assign unf[g] = read_en[g] && empty[g];
    assign mis[g] = cnt != sh || cnt > FULL_V || full[g] != (sh == FULL_V) || empty[g] != (sh == '0);
    assign high_water[g*W +: W] = hw;
    // shadow occupancy and high-water mark; clear reloads the mark from the current occupancy
    always_ff @(posedge clk or negedge rst_q)
      if (!rst_q) begin
        sh <= '0;
        hw <= '0;
      end else begin
        sh <= sh_nx;
        hw <= clear ? sh : (sh_nx > hw) ? sh_nx : hw;
      end
`ifdef FIFO_CHANNEL_MONITOR_SVA_EN
    a_ovf: assert property (@(posedge clk) disable iff (!reset_n) !ovf[g]) else $error("overflow on channel %0d", g);
    a_unf: assert property (@(posedge clk) disable iff (!reset_n) !unf[g]) else $error("underflow on channel %0d", g);
    a_mis: assert property (@(posedge clk) disable iff (!reset_n) !mis[g]) else $error("status mismatch on channel %0d", g);
    a_cnt: assert property (@(posedge clk) disable iff (!reset_n) cnt <= FULL_V) else $error("count above depth on channel %0d", g);
`else
`endif
  end
  assign any_v = |{ovf, unf, mis};
  assign err_any = |{err_overflow, err_underflow, err_mismatch};
  // lowest violating channel wins; within a channel overflow beats underflow beats mismatch
  always_comb begin
    f_chan = '0;
    f_code = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (ovf[i] || unf[i] || mis[i]) begin
        f_chan = CH_W'(i);
        f_code = ovf[i] ? 2'd1 : unf[i] ? 2'd2 : 2'd3;
      end
  end
  // sticky flags, saturating event counter and first-error capture; a new violation beats clear
  always_ff @(posedge clk or negedge rst_q)
    if (!rst_q) begin
      err_overflow    <= '0;
      err_underflow   <= '0;
      err_mismatch    <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_chan  <= '0;
      first_err_code  <= '0;
    end else begin
      err_overflow    <= (clear ? '0 : err_overflow) | ovf;
      err_underflow   <= (clear ? '0 : err_underflow) | unf;
      err_mismatch    <= (clear ? '0 : err_mismatch) | mis;
      err_count       <= clear ? ERR_CNT_W'(any_v) : (any_v && ~&err_count) ? err_count + ERR_CNT_W'(1) : err_count;
      first_err_valid <= (first_err_valid && !clear) || any_v;
      if (clear || !first_err_valid) begin
        first_err_chan <= f_chan;
        first_err_code <= f_code;
      end
    end
endmodule

// File: tb/tb_fifo_channel_monitor.sv
// tb_fifo_channel_monitor: directed and randomized checks against an occupancy-level reference model
module tb_fifo_channel_monitor;
  localparam int CH = 4;
  localparam int DEPTH = 32;
  localparam int W = 6;
  logic clk = 0, reset_n = 1, clear = 0;
  logic [CH-1:0] write_en = '0, read_en = '0, full = '0, empty = '0;
  logic [CH*W-1:0] count = '0;
  logic [CH-1:0] err_overflow, err_underflow, err_mismatch;
  logic err_any, first_err_valid;
  logic [CH*W-1:0] high_water;
  logic [7:0] err_count;
  logic [1:0] first_err_chan, first_err_code;
  int checks = 0, failures = 0;
  int sh_m[CH], hw_m[CH];
  logic [CH-1:0] ovf_m, unf_m, mis_m;
  int cnt_m, fc_m, fcode_m;
  bit fv_m;

  fifo_channel_monitor dut (
    .clk(clk), .reset_n(reset_n), .write_en(write_en), .read_en(read_en),
    .full(full), .empty(empty), .count(count), .clear(clear),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_mismatch(err_mismatch),
    .err_any(err_any), .high_water(high_water), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_chan(first_err_chan), .first_err_code(first_err_code)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      sh_m[i] = 0;
      hw_m[i] = 0;
    end
    ovf_m = '0; unf_m = '0; mis_m = '0;
    cnt_m = 0; fv_m = 0; fc_m = 0; fcode_m = 0;
  endtask

  task automatic idle();
    clear = 0; write_en = '0; read_en = '0;
    for (int i = 0; i < CH; i++) begin
      count[i*W +: W] = 6'(sh_m[i]);
      full[i] = (sh_m[i] == DEPTH);
      empty[i] = (sh_m[i] == 0);
    end
  endtask

  task automatic cycle();
    bit any, found, o, u, m;
    int c, nsh, fch, fcd;
    any = 0; found = 0; fch = 0; fcd = 0;
    for (int i = 0; i < CH; i++) begin
      c = int'(count[i*W +: W]);
      o = write_en[i] && full[i];
      u = read_en[i] && empty[i];
      m = (c != sh_m[i]) || (c > DEPTH) || (full[i] != (sh_m[i] == DEPTH)) || (empty[i] != (sh_m[i] == 0));
      if ((o || u || m) && !found) begin
        found = 1; fch = i; fcd = o ? 1 : u ? 2 : 3;
      end
      any = any | o | u | m;
      nsh = sh_m[i];
      if (write_en[i] && sh_m[i] != DEPTH) nsh = nsh + 1;
      if (read_en[i] && sh_m[i] != 0) nsh = nsh - 1;
      hw_m[i] = clear ? sh_m[i] : (nsh > hw_m[i] ? nsh : hw_m[i]);
      ovf_m[i] = (clear ? 1'b0 : ovf_m[i]) | o;
      unf_m[i] = (clear ? 1'b0 : unf_m[i]) | u;
      mis_m[i] = (clear ? 1'b0 : mis_m[i]) | m;
      sh_m[i] = nsh;
    end
    if (clear) cnt_m = any ? 1 : 0;
    else if (any && cnt_m < 255) cnt_m = cnt_m + 1;
    if (clear || !fv_m) begin
      fv_m = any; fc_m = any ? fch : 0; fcode_m = any ? fcd : 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    model_reset();
    idle();
    @(negedge clk) reset_n = 1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    idle();
    #2 reset_n = 0;
    #1;
    checks++; if (err_any !== 1'b0) begin failures++; $display("FAIL reset_err_any got %b exp 0", err_any); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    checks++; if ({err_overflow, err_underflow, err_mismatch, high_water, first_err_valid, first_err_chan, first_err_code} !== '0) begin
      failures++; $display("FAIL reset_outputs got %b/%b/%b hw %h fe %b%0d%0d exp all zero", err_overflow, err_underflow, err_mismatch, high_water, first_err_valid, first_err_chan, first_err_code);
    end
    release_reset();
    checks++; if ({err_any, err_count, high_water, first_err_valid} !== '0) begin failures++; $display("FAIL reset_release got any %b cnt %0d hw %h fv %b exp zeros", err_any, err_count, high_water, first_err_valid); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < DEPTH; k++) begin
      idle(); write_en = 4'b0001; cycle();
    end
    checks++; if (high_water[0 +: W] !== 6'd32) begin failures++; $display("FAIL fill_high_water got %0d exp 32", high_water[0 +: W]); end
    checks++; if (err_any !== 1'b0) begin failures++; $display("FAIL fill_err_any got %b exp 0", err_any); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL fill_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_overflow();
    idle(); write_en = 4'b0001; cycle();
    checks++; if (err_overflow !== 4'b0001) begin failures++; $display("FAIL ovf_sticky got %b exp 0001", err_overflow); end
    checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {1'b1, 2'd0, 2'd1}) begin failures++; $display("FAIL ovf_first got v%b ch%0d code%0d exp v1 ch0 code1", first_err_valid, first_err_chan, first_err_code); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL ovf_count got %0d exp 1", err_count); end
    idle(); cycle();
    checks++; if (err_mismatch !== 4'b0000 || err_count !== 8'd1) begin failures++; $display("FAIL ovf_sh_held got mis %b cnt %0d exp 0000 1", err_mismatch, err_count); end
  endtask

  task automatic test_coincident();
    idle(); clear = 1; cycle();
    checks++; if ({err_any, err_count, first_err_valid} !== '0) begin failures++; $display("FAIL clear_idle got any %b cnt %0d fv %b exp zeros", err_any, err_count, first_err_valid); end
    for (int k = 0; k < 4; k++) begin
      idle(); write_en = 4'b0010; cycle();
    end
    idle(); read_en = 4'b0100; count[1*W +: W] = 6'd5; cycle();
    checks++; if (err_underflow !== 4'b0100) begin failures++; $display("FAIL coin_underflow got %b exp 0100", err_underflow); end
    checks++; if (err_mismatch !== 4'b0010) begin failures++; $display("FAIL coin_mismatch got %b exp 0010", err_mismatch); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL coin_count got %0d exp 1", err_count); end
    checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {1'b1, 2'd1, 2'd3}) begin failures++; $display("FAIL coin_first got v%b ch%0d code%0d exp v1 ch1 code3", first_err_valid, first_err_chan, first_err_code); end
  endtask

  task automatic test_simul_full();
    for (int k = 0; k < DEPTH; k++) begin
      idle(); write_en = 4'b1000; cycle();
    end
    idle(); write_en = 4'b1000; read_en = 4'b1000; cycle();
    idle(); cycle();
    checks++; if (err_overflow[3] !== 1'b1) begin failures++; $display("FAIL simul_ovf got %b exp 1", err_overflow[3]); end
    checks++; if (err_mismatch[3] !== 1'b0) begin failures++; $display("FAIL simul_sh31 got mis %b exp 0", err_mismatch[3]); end
    checks++; if (high_water[3*W +: W] !== 6'd32) begin failures++; $display("FAIL simul_hw got %0d exp 32", high_water[3*W +: W]); end
  endtask

  task automatic test_clear_underflow();
    for (int k = 0; k < DEPTH; k++) begin
      idle(); read_en = 4'b0001; cycle();
    end
    idle(); clear = 1; read_en = 4'b0001; cycle();
    checks++; if ({err_overflow, err_underflow, err_mismatch} !== {4'b0000, 4'b0001, 4'b0000}) begin failures++; $display("FAIL clr_sticky got %b %b %b exp 0000 0001 0000", err_overflow, err_underflow, err_mismatch); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL clr_count got %0d exp 1", err_count); end
    checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {1'b1, 2'd0, 2'd2}) begin failures++; $display("FAIL clr_first got v%b ch%0d code%0d exp v1 ch0 code2", first_err_valid, first_err_chan, first_err_code); end
    checks++; if (high_water !== {6'd31, 6'd0, 6'd4, 6'd0}) begin failures++; $display("FAIL clr_hw got %h exp %h", high_water, {6'd31, 6'd0, 6'd4, 6'd0}); end
  endtask

  task automatic test_saturate_reset();
    for (int k = 0; k < 300; k++) begin
      idle(); count[2*W +: W] = count[2*W +: W] ^ 6'd1; cycle();
    end
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_count got %0d exp 255", err_count); end
    checks++; if (err_mismatch[2] !== 1'b1) begin failures++; $display("FAIL sat_mismatch got %b exp 1", err_mismatch[2]); end
    idle(); count[2*W +: W] = 6'd9; cycle();
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_hold got %0d exp 255", err_count); end
    #2 reset_n = 0;
    #1;
    checks++; if ({err_overflow, err_underflow, err_mismatch, err_any, high_water, err_count, first_err_valid, first_err_chan, first_err_code} !== '0) begin
      failures++; $display("FAIL midreset_outputs got cnt %0d any %b hw %h fv %b exp all zero", err_count, err_any, high_water, first_err_valid);
    end
    release_reset();
    checks++; if ({err_any, err_count, high_water} !== '0) begin failures++; $display("FAIL midreset_release got any %b cnt %0d hw %h exp zeros", err_any, err_count, high_water); end
  endtask

  task automatic test_random();
    logic [CH*W-1:0] exp_hw;
    int c;
    for (int n = 0; n < 3000; n++) begin
      idle();
      write_en = 4'($urandom);
      read_en = 4'($urandom);
      if ((n / 250) % 2 == 0) read_en = read_en & 4'($urandom);
      else write_en = write_en & 4'($urandom);
      clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 12) == 0) begin
        c = $urandom_range(0, CH - 1);
        case ($urandom_range(0, 3))
          0: full[c] = ~full[c];
          1: empty[c] = ~empty[c];
          2: count[c*W +: W] = count[c*W +: W] + 6'($urandom_range(1, 3));
          default: count[c*W +: W] = 6'($urandom_range(33, 63));
        endcase
      end
      cycle();
      for (int i = 0; i < CH; i++) exp_hw[i*W +: W] = 6'(hw_m[i]);
      checks++; if ({err_overflow, err_underflow, err_mismatch} !== {ovf_m, unf_m, mis_m}) begin failures++; $display("FAIL rand_sticky cyc %0d got %b %b %b exp %b %b %b", n, err_overflow, err_underflow, err_mismatch, ovf_m, unf_m, mis_m); end
      checks++; if (high_water !== exp_hw) begin failures++; $display("FAIL rand_hw cyc %0d got %h exp %h", n, high_water, exp_hw); end
      checks++; if (err_count !== 8'(cnt_m)) begin failures++; $display("FAIL rand_count cyc %0d got %0d exp %0d", n, err_count, cnt_m); end
      checks++; if (err_any !== (|{ovf_m, unf_m, mis_m})) begin failures++; $display("FAIL rand_any cyc %0d got %b exp %b", n, err_any, |{ovf_m, unf_m, mis_m}); end
      checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {fv_m, 2'(fc_m), 2'(fcode_m)}) begin
        failures++; $display("FAIL rand_first cyc %0d got v%b ch%0d code%0d exp v%b ch%0d code%0d", n, first_err_valid, first_err_chan, first_err_code, fv_m, fc_m, fcode_m);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_coincident();
    test_simul_full();
    test_clear_underflow();
    test_saturate_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
